i2c_tx_fifo_arbiter: RTL and testbench

//   Round-robin arbiter that shares the write port of the I2C transmit FIFO among NUM_REQ requesters.

---
 rtl/i2c_tx_fifo_arbiter_if.sv | 35 +++
 rtl/i2c_tx_fifo_arbiter.sv | 151 +++++++++++++++
 tb/tb_i2c_tx_fifo_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_tx_fifo_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_tx_fifo_arbiter_if
// Brief    : Requester and FIFO write-side bundle for the transmit FIFO arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_tx_fifo_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          fifo_full;
    logic                          busy;
    logic                          abort;
    logic [c_IDX_W-1:0]            abort_id;

    modport master (
        output req, req_data, req_last, fifo_full,
        input  req_ready, gnt, fifo_wr_en, fifo_din, busy, abort, abort_id
    );

    modport slave (
        input  req, req_data, req_last, fifo_full,
        output req_ready, gnt, fifo_wr_en, fifo_din, busy, abort, abort_id
    );
endinterface
`default_nettype wire

// File: rtl/i2c_tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_tx_fifo_arbiter
// Brief    : Packet-locked round-robin arbiter for the I2C TX FIFO write port,
//            with idle timeout release and abort reporting.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_tx_fifo_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_tx_fifo_arbiter_if.slave  bus
);
    localparam int                 c_IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                 c_TO_EN    = (TIMEOUT != 0);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX  = c_IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [NUM_REQ-1:0]    r_gnt,      w_gnt_nxt;
    logic [c_IDX_W-1:0]    r_cur_idx,  w_cur_idx_nxt;
    logic [c_IDX_W-1:0]    r_last_idx, w_last_idx_nxt;
    logic [c_CNT_W-1:0]    r_cnt,      w_cnt_nxt;
    logic                  r_abort,    w_abort_nxt;
    logic [c_IDX_W-1:0]    r_abort_id, w_abort_id_nxt;

    logic                  w_pick_valid;
    logic [c_IDX_W-1:0]    w_pick_idx;
    logic                  w_req_g;
    logic                  w_last_g;
    logic [DATA_WIDTH-1:0] w_din_g;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_din;

    // Round-robin pick: lowest requester above last_gnt wins, else lowest at or below it.
    always_comb begin
        w_pick_valid = |bus.req;
        w_pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i] && (i <= int'(r_last_idx))) w_pick_idx = c_IDX_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i] && (i > int'(r_last_idx))) w_pick_idx = c_IDX_W'(i);
        end
    end

    always_comb begin
        w_req_g  = 1'b0;
        w_last_g = 1'b0;
        w_din_g  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_cur_idx == c_IDX_W'(i)) begin
                w_req_g  = bus.req[i];
                w_last_g = bus.req_last[i];
                w_din_g  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_cur_idx_nxt  = r_cur_idx;
        w_last_idx_nxt = r_last_idx;
        w_cnt_nxt      = r_cnt;
        w_abort_nxt    = 1'b0;
        w_abort_id_nxt = r_abort_id;
        w_ready        = '0;
        w_wr_en        = 1'b0;
        w_din          = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt   = ST_XFER;
                    w_gnt_nxt     = c_ONE << w_pick_idx;
                    w_cur_idx_nxt = w_pick_idx;
                    w_cnt_nxt     = '0;
                end
            end
            ST_XFER: begin
                w_ready = r_gnt & {NUM_REQ{!bus.fifo_full}};
                w_wr_en = w_req_g && !bus.fifo_full;
                w_din   = w_din_g;
                if (w_req_g) begin
                    // A stalled-but-valid requester is not idle; only a dropped req counts.
                    w_cnt_nxt = '0;
                    if (!bus.fifo_full && w_last_g) begin
                        w_state_nxt    = ST_IDLE;
                        w_gnt_nxt      = '0;
                        w_last_idx_nxt = r_cur_idx;
                    end
                end else if (c_TO_EN) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt    = ST_IDLE;
                        w_gnt_nxt      = '0;
                        w_last_idx_nxt = r_cur_idx;
                        w_cnt_nxt      = '0;
                        w_abort_nxt    = 1'b1;
                        w_abort_id_nxt = r_cur_idx;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_cur_idx  <= '0;
            r_last_idx <= c_IDX_MAX;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
            r_abort_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_cur_idx  <= w_cur_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_abort    <= w_abort_nxt;
            r_abort_id <= w_abort_id_nxt;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.gnt        = r_gnt;
    assign bus.fifo_wr_en = w_wr_en;
    assign bus.fifo_din   = w_din;
    assign bus.busy       = (r_state == ST_XFER);
    assign bus.abort      = r_abort;
    assign bus.abort_id   = r_abort_id;
endmodule
`default_nettype wire

// File: tb/tb_i2c_tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_tx_fifo_arbiter
// Brief    : Directed self-checking bench for i2c_tx_fifo_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_tx_fifo_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_tx_fifo_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifa ();
    i2c_tx_fifo_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifb ();

    i2c_tx_fifo_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    i2c_tx_fifo_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_guard = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write strobe must only ever fire for the granted, requesting owner while not full.
    always @(negedge clk) begin
        if (rst_n && ifa.fifo_wr_en &&
            (ifa.fifo_full || !ifa.busy || ((ifa.req & ifa.gnt) == '0)))
            n_guard++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  exp_order [5];
        bit  seen_abort;
        exp_order = '{0, 1, 2, 3, 0};

        ifa.req = '0; ifa.req_data = '0; ifa.req_last = '0; ifa.fifo_full = 1'b0;
        ifb.req = '0; ifb.req_data = '0; ifb.req_last = '0; ifb.fifo_full = 1'b0;
        tick();
        tick();
        check("rst_gnt",      32'(ifa.gnt),        32'h0);
        check("rst_busy",     32'(ifa.busy),       32'h0);
        check("rst_abort",    32'(ifa.abort),      32'h0);
        check("rst_abort_id", 32'(ifa.abort_id),   32'h0);
        check("rst_wr_en",    32'(ifa.fifo_wr_en), 32'h0);
        rst_n = 1'b1;

        // 1: three-beat packet from requester 0
        ifa.req = 4'b0001; ifa.req_data = 32'h0000_00A1;
        #1;
        check("t1_gnt_pre", 32'(ifa.gnt), 32'h0);
        tick();
        check("t1_gnt",  32'(ifa.gnt),  32'h1);
        check("t1_busy", 32'(ifa.busy), 32'h1);
        for (int b = 0; b < 3; b++) begin
            ifa.req_data[7:0] = 8'hA1 + 8'(b);
            ifa.req_last      = (b == 2) ? 4'b0001 : 4'b0000;
            #1;
            check("t1_wr_en", 32'(ifa.fifo_wr_en), 32'h1);
            check("t1_din",   32'(ifa.fifo_din),   32'hA1 + 32'(b));
            check("t1_ready", 32'(ifa.req_ready),  32'h1);
            tick();
        end
        ifa.req = '0; ifa.req_last = '0;
        #1;
        check("t1_gnt_end",  32'(ifa.gnt),        32'h0);
        check("t1_busy_end", 32'(ifa.busy),       32'h0);
        check("t1_wr_end",   32'(ifa.fifo_wr_en), 32'h0);

        // 2: all requesting single-beat packets, fresh rotation after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifa.req = 4'b1111; ifa.req_last = 4'b1111; ifa.req_data = 32'hD3D2_D1D0;
        #1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_gnt",   32'(ifa.gnt),        32'(1) << exp_order[k]);
            check("t2_din",   32'(ifa.fifo_din),   32'hD0 + 32'(exp_order[k]));
            check("t2_wr_en", 32'(ifa.fifo_wr_en), 32'h1);
            tick();
            check("t2_gap_gnt",  32'(ifa.gnt),  32'h0);
            check("t2_gap_busy", 32'(ifa.busy), 32'h0);
        end
        ifa.req = '0; ifa.req_last = '0;

        // 3: requester 2 stalled by fifo_full for 10 cycles
        ifa.req = 4'b0100; ifa.req_data = 32'h00C1_0000;
        #1;
        tick();
        check("t3_gnt",   32'(ifa.gnt),        32'h4);
        check("t3_wr_en", 32'(ifa.fifo_wr_en), 32'h1);
        check("t3_din",   32'(ifa.fifo_din),   32'hC1);
        tick();
        ifa.fifo_full = 1'b1; ifa.req_data[23:16] = 8'hC2; ifa.req_last = 4'b0100;
        #1;
        for (int c = 0; c < 10; c++) begin
            check("t3_full_wr",    32'(ifa.fifo_wr_en), 32'h0);
            check("t3_full_ready", 32'(ifa.req_ready),  32'h0);
            check("t3_full_gnt",   32'(ifa.gnt),        32'h4);
            check("t3_full_abort", 32'(ifa.abort),      32'h0);
            tick();
        end
        ifa.fifo_full = 1'b0;
        #1;
        check("t3_res_wr",    32'(ifa.fifo_wr_en), 32'h1);
        check("t3_res_din",   32'(ifa.fifo_din),   32'hC2);
        check("t3_res_ready", 32'(ifa.req_ready),  32'h4);
        tick();
        ifa.req = '0; ifa.req_last = '0;
        #1;
        check("t3_gnt_end", 32'(ifa.gnt), 32'h0);

        // 4: requester 1 stalls after one beat; timeout of 4 idle cycles
        ifa.req = 4'b0010; ifa.req_data[15:8] = 8'hB1;
        #1;
        tick();
        check("t4_gnt",   32'(ifa.gnt),        32'h2);
        check("t4_wr_en", 32'(ifa.fifo_wr_en), 32'h1);
        tick();
        ifa.req = 4'b0100;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("t4_idle_abort", 32'(ifa.abort),      32'h0);
            check("t4_idle_gnt",   32'(ifa.gnt),        32'h2);
            check("t4_idle_wr",    32'(ifa.fifo_wr_en), 32'h0);
            tick();
        end
        check("t4_abort",    32'(ifa.abort),    32'h1);
        check("t4_abort_id", 32'(ifa.abort_id), 32'h1);
        check("t4_gnt_rel",  32'(ifa.gnt),      32'h0);
        check("t4_busy_rel", 32'(ifa.busy),     32'h0);
        tick();
        check("t4_abort_pulse", 32'(ifa.abort),    32'h0);
        check("t4_abort_hold",  32'(ifa.abort_id), 32'h1);
        check("t4_next_gnt",    32'(ifa.gnt),      32'h4);
        ifa.req_data[23:16] = 8'hC3; ifa.req_last = 4'b0100;
        #1;
        check("t4_next_din", 32'(ifa.fifo_din), 32'hC3);
        tick();
        ifa.req = '0; ifa.req_last = '0;

        // 5: asynchronous reset in the middle of a requester 3 packet
        ifa.req = 4'b1000; ifa.req_data[31:24] = 8'hE1;
        #1;
        tick();
        check("t5_gnt", 32'(ifa.gnt), 32'h8);
        tick();
        #1;
        check("t5_wr_pre", 32'(ifa.fifo_wr_en), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_gnt",  32'(ifa.gnt),        32'h0);
        check("t5_rst_busy", 32'(ifa.busy),       32'h0);
        check("t5_rst_wr",   32'(ifa.fifo_wr_en), 32'h0);
        tick();
        rst_n = 1'b1;
        ifa.req = 4'b1001; ifa.req_last = 4'b1001; ifa.req_data[7:0] = 8'hF0;
        #1;
        tick();
        check("t5_first_gnt", 32'(ifa.gnt),      32'h1);
        check("t5_first_din", 32'(ifa.fifo_din), 32'hF0);
        tick();
        ifa.req = '0; ifa.req_last = '0;

        // 6: timeout disabled, grant held through a long idle stretch
        ifb.req = 4'b0001; ifb.req_data = 32'h0000_0055;
        #1;
        tick();
        check("t6_gnt", 32'(ifb.gnt), 32'h1);
        tick();
        ifb.req = '0;
        seen_abort = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (ifb.abort) seen_abort = 1'b1;
        end
        check("t6_no_abort", 32'(seen_abort), 32'h0);
        check("t6_gnt_held", 32'(ifb.gnt),    32'h1);
        check("t6_busy",     32'(ifb.busy),   32'h1);
        ifb.req = 4'b0001; ifb.req_last = 4'b0001;
        #1;
        check("t6_wr_en", 32'(ifb.fifo_wr_en), 32'h1);
        tick();
        ifb.req = '0; ifb.req_last = '0;
        #1;
        check("t6_gnt_end", 32'(ifb.gnt), 32'h0);

        check("wr_guard", 32'(n_guard), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
